lidar_header_parser: RTL
========================

LIDAR_HEADER_PARSER -- requirements
Module: lidar_header_parser

Interface
REQ-001 SHALL have parameter POINT_BYTES, default 16: payload bytes per point.
REQ-002 SHALL have parameter MAX_VERSION, default 8'h0F: highest legal version byte.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 255: header idle-cycle limit, used only under REQ-029.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port in_data, input, 8: stream byte.
REQ-007 SHALL have ports in_valid and in_sop, input, 1 each: byte valid; first byte of frame.
REQ-008 SHALL have port in_ready, output, 1: byte accepted when in_valid and in_ready are both high.
REQ-009 SHALL have ports version (8), point_count (24) and header_length (8, in bits), all outputs: decoded header fields.
REQ-010 SHALL have ports hdr_valid (output, 1), hdr_ready (input, 1) and header_error (output, 1): header result handshake and error flag.
REQ-011 SHALL have ports out_data (output, 8), out_valid (output, 1), out_ready (input, 1) and out_last (output, 1): payload stream.
REQ-012 SHALL have port abort, output, 1: one-cycle pulse when a frame is abandoned.

Function
REQ-013 SHALL implement states IDLE, HDR, EMIT, PAYLOAD and DROP.
REQ-014 in_ready SHALL be 1 in IDLE, HDR and DROP, equal to out_ready in PAYLOAD, and 0 in EMIT.
REQ-015 In IDLE, accepted bytes without in_sop SHALL be discarded; an accepted in_sop byte SHALL be latched as version and the block SHALL go to HDR.
REQ-016 Version 0x01 SHALL collect 2 count bytes, MSB first, header_length 24.
REQ-017 Version 0x02 SHALL collect 3 count bytes, MSB first, header_length 32.
REQ-018 A version of 0x00, above MAX_VERSION, or in 0x03..MAX_VERSION (legal but unsupported) SHALL go directly to EMIT with header_error=1, point_count=0 and header_length=0.
REQ-019 In HDR, after the last count byte is accepted, the block SHALL enter EMIT on the next cycle.
REQ-020 In EMIT, hdr_valid=1 and all header outputs SHALL be held stable until hdr_ready=1.
REQ-021 On the hdr_valid/hdr_ready handshake, the next state SHALL be DROP if header_error=1, IDLE if point_count=0, and PAYLOAD otherwise.
REQ-022 On entry to PAYLOAD, the remaining-byte counter SHALL be loaded with point_count*POINT_BYTES, computed at 32-bit width with no truncation.
REQ-023 In PAYLOAD, out_data SHALL equal in_data and out_valid SHALL equal in_valid, combinationally; each transfer SHALL decrement the counter.
REQ-024 out_last SHALL be 1 when the counter equals 1; after that transfer the block SHALL return to IDLE.
REQ-025 An accepted in_sop byte in HDR, PAYLOAD or DROP SHALL restart parsing with that byte as the version byte. In HDR or PAYLOAD it SHALL also pulse abort; in DROP it SHALL not.
REQ-026 In PAYLOAD, that in_sop byte SHALL NOT be forwarded: out_valid SHALL be 0 for it.
REQ-027 In DROP, non-sop bytes SHALL be accepted and discarded.

Reset
REQ-028 While rst=1, the block SHALL be in state IDLE with all counters cleared and all outputs 0, except in_ready, which SHALL be 1; asserting rst mid-frame SHALL discard the frame with no abort pulse.

Configuration
REQ-029 With macro HDR_TIMEOUT_EN defined, the block SHALL count consecutive HDR cycles with no accepted byte; on reaching TIMEOUT_CYC it SHALL pulse abort and return to IDLE, and the counter SHALL clear on each accepted byte or state exit.
REQ-030 Without HDR_TIMEOUT_EN, HDR SHALL wait indefinitely, no timeout logic SHALL be present, and TIMEOUT_CYC SHALL be ignored.

Verification
REQ-031 Input sop 0x01, 0x00, 0x02 then 32 bytes, with hdr_ready and out_ready held at 1 -> version 1, point_count 2, header_length 24, header_error 0; 32 payload bytes forwarded, out_last on the 32nd, then IDLE.
REQ-032 Input sop 0x02, 0x00, 0x00, 0x01 with hdr_ready held at 0 for 5 cycles -> hdr_valid held and fields stable for those cycles, in_ready 0, then 16 payload bytes with point_count 1 and header_length 32.
REQ-033 Input sop 0x05, then bytes 0xAA, 0xBB -> header_error 1, header_length 0, point_count 0; then DROP until the next sop byte.
REQ-034 Input sop 0x01, 0x00, 0x00 -> hdr_valid with point_count 0, then IDLE with no out_valid.
REQ-035 In PAYLOAD after 3 bytes, input sop 0x01 -> one-cycle abort pulse, that byte not forwarded, new header parsed.
REQ-036 With HDR_TIMEOUT_EN, input sop 0x02, 0x00, then idle for 255 cycles -> abort pulse, IDLE; without HDR_TIMEOUT_EN -> remains in HDR.

Source files
------------

// File: rtl/lidar_header_parser.sv
// LIDAR frame header parser: decodes version/point-count header and forwards the payload.
// Optional HDR_TIMEOUT_EN macro abandons a header that stalls for TIMEOUT_CYC idle cycles.
module lidar_header_parser #(
  parameter int unsigned POINT_BYTES = 16,
  parameter logic [7:0]  MAX_VERSION = 8'h0F,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_sop,
  output logic        in_ready,
  output logic [7:0]  version,
  output logic [23:0] point_count,
  output logic [7:0]  header_length,
  output logic        hdr_valid,
  input  logic        hdr_ready,
  output logic        header_error,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        abort
);

  typedef enum logic [2:0] {IDLE, HDR, EMIT, PAYLOAD, DROP} state_t;

  state_t      state_q, state_d;
  logic [7:0]  version_q, version_d;
  logic [23:0] count_q, count_d;
  logic [7:0]  hdrLen_q, hdrLen_d;
  logic        err_q, err_d;
  logic [1:0]  need_q, need_d;
  logic [31:0] remain_q, remain_d;
  logic        abort_q, abort_d;
`ifdef HDR_TIMEOUT_EN
  logic [31:0] idle_q, idle_d;
`endif

  logic       byteAccept, sopAccept;
  logic       decLegal, decErr;
  logic [1:0] decNeed;
  logic [7:0] decLen;

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      IDLE, HDR, DROP: in_ready = 1'b1;
      PAYLOAD:         in_ready = out_ready;
      default:         in_ready = 1'b0;
    endcase
  end

  assign byteAccept = in_valid && in_ready;
  assign sopAccept  = byteAccept && in_sop;

  // Version decode for a freshly accepted sop byte; unsupported versions skip straight to EMIT.
  always_comb begin
    decLegal = (in_data != 8'h00) && (in_data <= MAX_VERSION);
    decErr   = 1'b1;
    decNeed  = 2'd0;
    decLen   = 8'd0;
    if (decLegal && in_data == 8'h01) begin
      decErr  = 1'b0;
      decNeed = 2'd2;
      decLen  = 8'd24;
    end else if (decLegal && in_data == 8'h02) begin
      decErr  = 1'b0;
      decNeed = 2'd3;
      decLen  = 8'd32;
    end
  end

  always_comb begin
    state_d   = state_q;
    version_d = version_q;
    count_d   = count_q;
    hdrLen_d  = hdrLen_q;
    err_d     = err_q;
    need_d    = need_q;
    remain_d  = remain_q;
    abort_d   = 1'b0;
    hdr_valid = 1'b0;
    out_valid = 1'b0;
    out_data  = 8'h00;
    out_last  = 1'b0;
    case (state_q)
      HDR: begin
        if (byteAccept && !in_sop) begin
          count_d = {count_q[15:0], in_data};
          need_d  = need_q - 2'd1;
          if (need_q == 2'd1) state_d = EMIT;
        end
      end
      EMIT: begin
        hdr_valid = 1'b1;
        if (hdr_ready) begin
          if (err_q)                 state_d = DROP;
          else if (count_q == 24'd0) state_d = IDLE;
          else begin
            state_d  = PAYLOAD;
            remain_d = 32'(count_q) * 32'(POINT_BYTES);
          end
        end
      end
      PAYLOAD: begin
        out_data  = in_data;
        out_valid = in_valid && !in_sop;
        out_last  = (remain_q == 32'd1);
        if (byteAccept && !in_sop) begin
          remain_d = remain_q - 32'd1;
          if (remain_q == 32'd1) state_d = IDLE;
        end
      end
      default: ;
    endcase

`ifdef HDR_TIMEOUT_EN
    idle_d = 32'd0;
    if (state_q == HDR && !byteAccept) begin
      idle_d = idle_q + 32'd1;
      if (idle_d >= 32'(TIMEOUT_CYC)) begin
        idle_d  = 32'd0;
        state_d = IDLE;
        abort_d = 1'b1;
      end
    end
`endif

    // A sop byte always restarts parsing; only a frame in progress counts as abandoned.
    if (sopAccept) begin
      version_d = in_data;
      count_d   = 24'd0;
      hdrLen_d  = decLen;
      err_d     = decErr;
      need_d    = decNeed;
      remain_d  = 32'd0;
      state_d   = decErr ? EMIT : HDR;
      abort_d   = (state_q == HDR) || (state_q == PAYLOAD);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      version_q <= 8'h00;
      count_q   <= 24'd0;
      hdrLen_q  <= 8'd0;
      err_q     <= 1'b0;
      need_q    <= 2'd0;
      remain_q  <= 32'd0;
      abort_q   <= 1'b0;
`ifdef HDR_TIMEOUT_EN
      idle_q    <= 32'd0;
`endif
    end else begin
      state_q   <= state_d;
      version_q <= version_d;
      count_q   <= count_d;
      hdrLen_q  <= hdrLen_d;
      err_q     <= err_d;
      need_q    <= need_d;
      remain_q  <= remain_d;
      abort_q   <= abort_d;
`ifdef HDR_TIMEOUT_EN
      idle_q    <= idle_d;
`endif
    end
  end

  assign version       = version_q;
  assign point_count   = count_q;
  assign header_length = hdrLen_q;
  assign header_error  = err_q;
  assign abort         = abort_q;

endmodule
